// File: rtl/wasde_menu_ctrl.sv
// Purpose : debounced WASDE button front end plus a browse/play FSM for song and mode selection.
// Latency : a stable level from sample edge N pulses key_pulse at edge N+DEBOUNCE_CYCLES+2; FSM outputs follow one edge later.
// Backpr. : none; key pulses are single-cycle events and are acted on or discarded in that same cycle.
//
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   WASDE_Signal   raw button levels [4]=W [3]=A [2]=S [1]=D [0]=E
//   song_done      one-cycle end-of-song pulse from the player
//   key_pulse      one-cycle pulse per debounced rising edge (same bit map)
//   song_idx       selected song, mode_idx selected play mode
//   playing        high in PLAY; play_start / play_stop one-cycle requests to the player
module wasde_menu_ctrl #(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int NUM_SONGS       = 3,
    parameter int NUM_MODES       = 3,
    parameter int SONG_W          = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        WASDE_Signal,
    input  logic              song_done,
    output logic [4:0]        key_pulse,
    output logic [SONG_W-1:0] song_idx,
    output logic [1:0]        mode_idx,
    output logic              playing,
    output logic              play_start,
    output logic              play_stop
);

    localparam int                CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SONG_W-1:0] SONG_MAX = SONG_W'(NUM_SONGS - 1);
    localparam logic [1:0]        MODE_MAX = 2'(NUM_MODES - 1);

    // Button bit positions
    localparam int K_W = 4;
    localparam int K_A = 3;
    localparam int K_S = 2;
    localparam int K_D = 1;
    localparam int K_E = 0;

    typedef enum logic {
        BROWSE = 1'b0,
        PLAY   = 1'b1
    } state_t;

    logic [4:0]       sync1;
    logic [4:0]       sync2;
    logic [4:0]       deb;      // accepted (debounced) levels
    logic [4:0]       deb_d;    // deb delayed one cycle, for rising-edge detect
    logic [CNT_W-1:0] cnt [5];
    state_t           state;

    // Input path: 2-flop synchronizer -> per-bit debounce counter -> rising-edge pulse.
    // The counter only runs while the synchronized bit disagrees with the accepted
    // level, so any agreement (a bounce back) restarts the hold window from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= '0;
            sync2     <= '0;
            deb       <= '0;
            deb_d     <= '0;
            key_pulse <= '0;
            for (int i = 0; i < 5; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1     <= WASDE_Signal;
            sync2     <= sync1;
            deb_d     <= deb;
            key_pulse <= deb & ~deb_d;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Browse/play FSM. The if/else chains encode command priority E > W > S > A > D;
    // lower-priority pulses arriving in the same cycle are dropped.
    // In PLAY, song_done is checked before E so a simultaneous E is swallowed
    // without issuing a redundant stop to a player that already finished.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BROWSE;
            song_idx   <= '0;
            mode_idx   <= '0;
            playing    <= 1'b0;
            play_start <= 1'b0;
            play_stop  <= 1'b0;
        end else begin
            play_start <= 1'b0;
            play_stop  <= 1'b0;
            case (state)
                BROWSE: begin
                    if (key_pulse[K_E]) begin
                        play_start <= 1'b1;
                        playing    <= 1'b1;
                        state      <= PLAY;
                    end else if (key_pulse[K_W]) begin
                        song_idx <= (song_idx == '0) ? SONG_MAX : song_idx - 1'b1;
                    end else if (key_pulse[K_S]) begin
                        song_idx <= (song_idx == SONG_MAX) ? '0 : song_idx + 1'b1;
                    end else if (key_pulse[K_A]) begin
                        mode_idx <= (mode_idx == 2'd0) ? MODE_MAX : mode_idx - 1'b1;
                    end else if (key_pulse[K_D]) begin
                        mode_idx <= (mode_idx == MODE_MAX) ? 2'd0 : mode_idx + 1'b1;
                    end
                end
                PLAY: begin
                    if (song_done) begin
                        playing <= 1'b0;
                        state   <= BROWSE;
                    end else if (key_pulse[K_E]) begin
                        play_stop <= 1'b1;
                        playing   <= 1'b0;
                        state     <= BROWSE;
                    end
                end
                default: begin
                    state <= BROWSE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wasde_menu_ctrl.sv
// Purpose : self-checking bench for wasde_menu_ctrl with a short debounce window.
// Latency : n/a (bench).
// Backpr. : n/a (bench).
module tb_wasde_menu_ctrl;

    localparam int DEB = 4;

    localparam logic [4:0] BW = 5'b10000;
    localparam logic [4:0] BA = 5'b01000;
    localparam logic [4:0] BS = 5'b00100;
    localparam logic [4:0] BD = 5'b00010;
    localparam logic [4:0] BE = 5'b00001;

    logic       clk;
    logic       rst;
    logic [4:0] WASDE_Signal;
    logic       song_done;
    logic [4:0] key_pulse;
    logic [3:0] song_idx;
    logic [1:0] mode_idx;
    logic       playing;
    logic       play_start;
    logic       play_stop;

    wasde_menu_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .NUM_SONGS      (3),
        .NUM_MODES      (3),
        .SONG_W         (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .WASDE_Signal(WASDE_Signal),
        .song_done   (song_done),
        .key_pulse   (key_pulse),
        .song_idx    (song_idx),
        .mode_idx    (mode_idx),
        .playing     (playing),
        .play_start  (play_start),
        .play_stop   (play_stop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_fail = 0;

    // Event counters accumulated by step()
    int         npulse;
    int         first_at;
    int         nstart;
    int         nstop;
    int         nboth;
    int         stepno;
    logic [4:0] lastpulse;

    typedef struct {
        logic [4:0] btn;
        int         song;
        int         mode;
        int         play;
        int         starts;
        int         stops;
        string      name;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        npulse    = 0;
        first_at  = 0;
        nstart    = 0;
        nstop     = 0;
        nboth     = 0;
        stepno    = 0;
        lastpulse = '0;
    endtask

    task automatic step();
        tick();
        stepno++;
        if (key_pulse != 5'b0) begin
            npulse++;
            if (first_at == 0) first_at = stepno;
            lastpulse = key_pulse;
        end
        if (play_start) nstart++;
        if (play_stop) nstop++;
        if (play_start && play_stop) nboth++;
    endtask

    task automatic run(input logic [4:0] b, input int cyc);
        WASDE_Signal = b;
        for (int i = 0; i < cyc; i++) step();
    endtask

    task automatic press(input logic [4:0] b);
        run(b, 10);
        run(5'b0, 10);
    endtask

    initial begin
        vecs[0]  = '{BW, 0, 0, 0, 0, 0, "W 1->0"};
        vecs[1]  = '{BW, 2, 0, 0, 0, 0, "W wrap 0->2"};
        vecs[2]  = '{BS, 0, 0, 0, 0, 0, "S wrap 2->0"};
        vecs[3]  = '{BS, 1, 0, 0, 0, 0, "S 0->1"};
        vecs[4]  = '{BD, 1, 1, 0, 0, 0, "D 0->1"};
        vecs[5]  = '{BD, 1, 2, 0, 0, 0, "D 1->2"};
        vecs[6]  = '{BD, 1, 0, 0, 0, 0, "D wrap 2->0"};
        vecs[7]  = '{BA, 1, 2, 0, 0, 0, "A wrap 0->2"};
        vecs[8]  = '{BA, 1, 1, 0, 0, 0, "A 2->1"};
        vecs[9]  = '{BE, 1, 1, 1, 1, 0, "E start"};
        vecs[10] = '{BW, 1, 1, 1, 0, 0, "W in PLAY"};
        vecs[11] = '{BD, 1, 1, 1, 0, 0, "D in PLAY"};
        vecs[12] = '{BE, 1, 1, 0, 0, 1, "E stop"};

        WASDE_Signal = 5'b0;
        song_done    = 1'b0;
        rst          = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("reset key_pulse", int'(key_pulse), 0);
        chk("reset song_idx", int'(song_idx), 0);
        chk("reset mode_idx", int'(mode_idx), 0);
        chk("reset playing", int'(playing), 0);
        chk("reset play_start", int'(play_start), 0);
        chk("reset play_stop", int'(play_stop), 0);
        tick();
        tick();
        rst = 1'b1;

        // Latency: S driven before edge N, pulse visible after edge N+DEB+2 (step DEB+3).
        clear_counts();
        WASDE_Signal = BS;
        for (int i = 0; i < DEB + 3; i++) step();
        chk("lat pulse step", first_at, DEB + 3);
        chk("lat song before", int'(song_idx), 0);
        step();
        chk("lat song after", int'(song_idx), 1);
        run(BS, 10 - (DEB + 4));
        run(5'b0, 10);
        chk("lat pulse count", npulse, 1);
        chk("lat pulse bits", int'(lastpulse), int'(BS));

        // Table-driven single presses
        for (int v = 0; v < 13; v++) begin
            clear_counts();
            press(vecs[v].btn);
            chk({vecs[v].name, " pulses"}, npulse, 1);
            chk({vecs[v].name, " key_pulse"}, int'(lastpulse), int'(vecs[v].btn));
            chk({vecs[v].name, " song_idx"}, int'(song_idx), vecs[v].song);
            chk({vecs[v].name, " mode_idx"}, int'(mode_idx), vecs[v].mode);
            chk({vecs[v].name, " playing"}, int'(playing), vecs[v].play);
            chk({vecs[v].name, " starts"}, nstart, vecs[v].starts);
            chk({vecs[v].name, " stops"}, nstop, vecs[v].stops);
        end

        // Short glitch and bounce: never held DEB cycles, so no pulse
        clear_counts();
        run(BS, 3);
        run(5'b0, 10);
        chk("glitch pulses", npulse, 0);
        chk("glitch song_idx", int'(song_idx), 1);
        clear_counts();
        run(BS, 1);
        run(5'b0, 1);
        run(BS, 1);
        run(5'b0, 10);
        chk("bounce pulses", npulse, 0);
        chk("bounce song_idx", int'(song_idx), 1);

        // song_done alone in PLAY
        clear_counts();
        press(BE);
        chk("enter play", int'(playing), 1);
        song_done = 1'b1;
        step();
        song_done = 1'b0;
        step();
        chk("done playing", int'(playing), 0);
        chk("done stops", nstop, 0);

        // song_done coincident with E pulse in PLAY
        press(BE);
        chk("reenter play", int'(playing), 1);
        clear_counts();
        WASDE_Signal = BE;
        for (int i = 0; i < DEB + 3; i++) step();
        chk("coinc E pulse", int'(key_pulse), int'(BE));
        song_done = 1'b1;
        step();
        song_done = 1'b0;
        chk("coinc playing", int'(playing), 0);
        chk("coinc stop now", int'(play_stop), 0);
        run(BE, 3);
        run(5'b0, 10);
        chk("coinc stops", nstop, 0);
        chk("coinc starts", nstart, 0);
        chk("coinc still browse", int'(playing), 0);

        // song_done in BROWSE is ignored
        clear_counts();
        song_done = 1'b1;
        step();
        song_done = 1'b0;
        run(5'b0, 3);
        chk("browse done playing", int'(playing), 0);
        chk("browse done starts", nstart, 0);

        // W+S+E together: only E acts
        clear_counts();
        press(BW | BS | BE);
        chk("multi key_pulse", int'(lastpulse), int'(BW | BS | BE));
        chk("multi starts", nstart, 1);
        chk("multi song_idx", int'(song_idx), 1);
        chk("multi playing", int'(playing), 1);
        clear_counts();
        press(BE);
        chk("multi exit stops", nstop, 1);
        chk("never both", nboth, 0);

        // Async reset mid-PLAY with song 2 / mode 1
        press(BS);
        press(BE);
        chk("pre-reset song", int'(song_idx), 2);
        chk("pre-reset mode", int'(mode_idx), 1);
        chk("pre-reset playing", int'(playing), 1);
        #3 rst = 1'b0;
        #1;
        chk("arst song_idx", int'(song_idx), 0);
        chk("arst mode_idx", int'(mode_idx), 0);
        chk("arst playing", int'(playing), 0);
        chk("arst start/stop", int'({play_start, play_stop}), 0);
        chk("arst key_pulse", int'(key_pulse), 0);
        WASDE_Signal = BE;
        tick();
        tick();
        rst = 1'b1;
        clear_counts();
        run(BE, 12);
        run(5'b0, 10);
        chk("held E pulses", npulse, 1);
        chk("held E starts", nstart, 1);
        chk("held E stops", nstop, 0);
        chk("held E playing", int'(playing), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
